pipe_wb_tracker: RTL and testbench

Pipeline-side producer of the writer-metadata interface that the forwarding/hazard unit consumes. It carries each instruction's register-write descriptor (wR, rf_we, rf_wsel, pc4, ext, alu_c, rd) through the ID/EX, EX/MEM and MEM/WB registers. It converts the hazard unit's `data_hazard` stall request and the EX-stage branch redirect into stall, flush and bubble controls. It also keeps stall/flush/retire performance counters.

---
 rtl/pipe_wb_tracker_pkg.sv | 33 +++
 rtl/pipe_wb_tracker_if.sv | 65 ++++++
 rtl/wb_stage_reg.sv | 34 +++
 rtl/pipe_wb_tracker.sv | 126 ++++++++++++
 tb/tb_pipe_wb_tracker.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_wb_tracker_pkg.sv
// Shared types and constants for the write-back descriptor tracker.
// The S_* write-back source codes mirror the system-wide defines.vh values.
package pipe_wb_tracker_pkg;

  localparam logic [1:0] S_ALU_C    = 2'd0;
  localparam logic [1:0] S_DRAM_rd  = 2'd1;
  localparam logic [1:0] S_PC4      = 2'd2;
  localparam logic [1:0] S_SEXT_ext = 2'd3;

  // Per-stage register-write descriptor. Later stages fill alu_c / rd.
  typedef struct packed {
    logic        valid;
    logic [4:0]  wr;
    logic        rf_we;
    logic [1:0]  rf_wsel;
    logic [31:0] pc4;
    logic [31:0] ext;
    logic [31:0] alu_c;
    logic [31:0] rd;
  } wb_desc_t;

  localparam wb_desc_t BubbleDesc = '{
    valid:   1'b0,
    wr:      5'd0,
    rf_we:   1'b0,
    rf_wsel: S_ALU_C,
    pc4:     32'd0,
    ext:     32'd0,
    alu_c:   32'd0,
    rd:      32'd0
  };

endpackage

// File: rtl/pipe_wb_tracker_if.sv
// Writer-metadata bus between the pipeline/hazard unit (master) and the
// descriptor tracker (slave).
// Master drives: ID_* descriptor, EX_alu_c, MEM_rd_in, data_hazard, EX_redirect.
// Slave drives: stall/flush controls, EX/MEM/WB descriptors, MEM_rd, counters.
interface pipe_wb_tracker_if #(
  parameter int unsigned CNT_W = 32
);
  logic             ID_valid;
  logic [4:0]       ID_wR;
  logic             ID_rf_we;
  logic [1:0]       ID_rf_wsel;
  logic [31:0]      ID_pc4;
  logic [31:0]      ID_ext;
  logic [31:0]      EX_alu_c;
  logic [31:0]      MEM_rd_in;
  logic             data_hazard;
  logic             EX_redirect;

  logic             pc_stall;
  logic             ifid_stall;
  logic             ifid_flush;
  logic [4:0]       EX_wR;
  logic             EX_rf_we;
  logic [1:0]       EX_rf_wsel;
  logic [31:0]      EX_pc4;
  logic [31:0]      EX_ext;
  logic [4:0]       MEM_wR;
  logic             MEM_rf_we;
  logic [1:0]       MEM_rf_wsel;
  logic [31:0]      MEM_pc4;
  logic [31:0]      MEM_ext;
  logic [31:0]      MEM_alu_c;
  logic [31:0]      MEM_rd;
  logic [4:0]       WB_wR;
  logic             WB_rf_we;
  logic [1:0]       WB_rf_wsel;
  logic [31:0]      WB_pc4;
  logic [31:0]      WB_ext;
  logic [31:0]      WB_alu_c;
  logic [31:0]      WB_rd;
  logic             WB_valid;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output ID_valid, ID_wR, ID_rf_we, ID_rf_wsel, ID_pc4, ID_ext, EX_alu_c, MEM_rd_in,
           data_hazard, EX_redirect,
    input  pc_stall, ifid_stall, ifid_flush,
           EX_wR, EX_rf_we, EX_rf_wsel, EX_pc4, EX_ext,
           MEM_wR, MEM_rf_we, MEM_rf_wsel, MEM_pc4, MEM_ext, MEM_alu_c, MEM_rd,
           WB_wR, WB_rf_we, WB_rf_wsel, WB_pc4, WB_ext, WB_alu_c, WB_rd, WB_valid,
           stall_cnt, flush_cnt, retire_cnt
  );

  modport slave (
    input  ID_valid, ID_wR, ID_rf_we, ID_rf_wsel, ID_pc4, ID_ext, EX_alu_c, MEM_rd_in,
           data_hazard, EX_redirect,
    output pc_stall, ifid_stall, ifid_flush,
           EX_wR, EX_rf_we, EX_rf_wsel, EX_pc4, EX_ext,
           MEM_wR, MEM_rf_we, MEM_rf_wsel, MEM_pc4, MEM_ext, MEM_alu_c, MEM_rd,
           WB_wR, WB_rf_we, WB_rf_wsel, WB_pc4, WB_ext, WB_alu_c, WB_rd, WB_valid,
           stall_cnt, flush_cnt, retire_cnt
  );
endinterface

// File: rtl/wb_stage_reg.sv
// One pipeline stage register for a write-back descriptor.
// Ports: clk/rst_n (async active-low), en_i load enable, bubble_i loads an
// empty descriptor instead of d_i, d_i next descriptor, q_o current descriptor.
module wb_stage_reg
  import pipe_wb_tracker_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en_i,
  input  logic     bubble_i,
  input  wb_desc_t d_i,
  output wb_desc_t q_o
);

  wb_desc_t desc_q, desc_d;

  always_comb begin
    desc_d = desc_q;
    if (en_i) begin
      desc_d = bubble_i ? BubbleDesc : d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      desc_q <= BubbleDesc;
    end else begin
      desc_q <= desc_d;
    end
  end

  assign q_o = desc_q;

endmodule

// File: rtl/pipe_wb_tracker.sv
// Carries register-write descriptors through ID/EX, EX/MEM and MEM/WB for the
// forwarding/hazard unit, turns data_hazard / EX_redirect into stall, flush
// and bubble controls, and counts stall, flush and retire cycles.
// Ports: clk, rst_n (async active-low), bus (slave side of pipe_wb_tracker_if).
module pipe_wb_tracker
  import pipe_wb_tracker_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_wb_tracker_if.slave   bus
);

  logic     stall;
  wb_desc_t id_ex_d, id_ex_q;
  wb_desc_t ex_mem_d, ex_mem_q;
  wb_desc_t mem_wb_d, mem_wb_q;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Redirect squashes the stalling ID instruction, so it overrides the stall.
  assign stall = bus.data_hazard & ~bus.EX_redirect;

  assign bus.pc_stall   = stall;
  assign bus.ifid_stall = stall;
  assign bus.ifid_flush = bus.EX_redirect;

  always_comb begin
    id_ex_d         = BubbleDesc;
    id_ex_d.valid   = bus.ID_valid;
    id_ex_d.wr      = bus.ID_wR;
    id_ex_d.rf_we   = bus.ID_rf_we;
    id_ex_d.rf_wsel = bus.ID_rf_wsel;
    id_ex_d.pc4     = bus.ID_pc4;
    id_ex_d.ext     = bus.ID_ext;

    ex_mem_d        = id_ex_q;
    ex_mem_d.alu_c  = bus.EX_alu_c;

    mem_wb_d        = ex_mem_q;
    mem_wb_d.rd     = bus.MEM_rd_in;
  end

  // EX instruction always advances on a redirect (jal/jalr may write rd);
  // only the wrong-path ID instruction is replaced by a bubble.
  wb_stage_reg u_id_ex (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (1'b1),
    .bubble_i (stall | bus.EX_redirect),
    .d_i      (id_ex_d),
    .q_o      (id_ex_q)
  );

  wb_stage_reg u_ex_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (1'b1),
    .bubble_i (1'b0),
    .d_i      (ex_mem_d),
    .q_o      (ex_mem_q)
  );

  wb_stage_reg u_mem_wb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (1'b1),
    .bubble_i (1'b0),
    .d_i      (mem_wb_d),
    .q_o      (mem_wb_q)
  );

  // rf_we is qualified by valid so a bubble can never match for forwarding.
  assign bus.EX_wR       = id_ex_q.wr;
  assign bus.EX_rf_we    = id_ex_q.valid & id_ex_q.rf_we;
  assign bus.EX_rf_wsel  = id_ex_q.rf_wsel;
  assign bus.EX_pc4      = id_ex_q.pc4;
  assign bus.EX_ext      = id_ex_q.ext;

  assign bus.MEM_wR      = ex_mem_q.wr;
  assign bus.MEM_rf_we   = ex_mem_q.valid & ex_mem_q.rf_we;
  assign bus.MEM_rf_wsel = ex_mem_q.rf_wsel;
  assign bus.MEM_pc4     = ex_mem_q.pc4;
  assign bus.MEM_ext     = ex_mem_q.ext;
  assign bus.MEM_alu_c   = ex_mem_q.alu_c;
  assign bus.MEM_rd      = bus.MEM_rd_in;

  assign bus.WB_wR       = mem_wb_q.wr;
  assign bus.WB_rf_we    = mem_wb_q.valid & mem_wb_q.rf_we;
  assign bus.WB_rf_wsel  = mem_wb_q.rf_wsel;
  assign bus.WB_pc4      = mem_wb_q.pc4;
  assign bus.WB_ext      = mem_wb_q.ext;
  assign bus.WB_alu_c    = mem_wb_q.alu_c;
  assign bus.WB_rd       = mem_wb_q.rd;
  assign bus.WB_valid    = mem_wb_q.valid;

  always_comb begin
    stall_cnt_d  = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    flush_cnt_d  = bus.EX_redirect ? sat_inc(flush_cnt_q) : flush_cnt_q;
    retire_cnt_d = mem_wb_q.valid ? sat_inc(retire_cnt_q) : retire_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;
  assign bus.retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_pipe_wb_tracker.sv
module tb_pipe_wb_tracker;
  import pipe_wb_tracker_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipe_wb_tracker_if #(.CNT_W(32)) bus ();
  pipe_wb_tracker_if #(.CNT_W(4))  bus_s ();

  // Narrow-counter instance sees identical stimulus.
  assign bus_s.ID_valid    = bus.ID_valid;
  assign bus_s.ID_wR       = bus.ID_wR;
  assign bus_s.ID_rf_we    = bus.ID_rf_we;
  assign bus_s.ID_rf_wsel  = bus.ID_rf_wsel;
  assign bus_s.ID_pc4      = bus.ID_pc4;
  assign bus_s.ID_ext      = bus.ID_ext;
  assign bus_s.EX_alu_c    = bus.EX_alu_c;
  assign bus_s.MEM_rd_in   = bus.MEM_rd_in;
  assign bus_s.data_hazard = bus.data_hazard;
  assign bus_s.EX_redirect = bus.EX_redirect;

  pipe_wb_tracker #(.CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipe_wb_tracker #(.CNT_W(4))  dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  task automatic idle();
    bus.ID_valid = 0; bus.ID_wR = 0; bus.ID_rf_we = 0; bus.ID_rf_wsel = S_ALU_C;
    bus.ID_pc4 = 0; bus.ID_ext = 0; bus.EX_alu_c = 0; bus.MEM_rd_in = 0;
    bus.data_hazard = 0; bus.EX_redirect = 0;
  endtask

  task automatic issue(input logic [4:0] wr, input logic we, input logic [1:0] wsel,
                       input logic [31:0] pc4, input logic [31:0] ext);
    bus.ID_valid = 1; bus.ID_wR = wr; bus.ID_rf_we = we; bus.ID_rf_wsel = wsel;
    bus.ID_pc4 = pc4; bus.ID_ext = ext;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    step();
    rst_n = 1;
    #1;
  endtask

  task automatic test_reset();
    logic [133:0] regs;
    do_reset();
    regs = {bus.EX_wR, bus.EX_rf_we, bus.EX_pc4, bus.EX_ext, bus.MEM_wR, bus.MEM_rf_we,
            bus.MEM_pc4, bus.MEM_ext, bus.WB_wR, bus.WB_rf_we, bus.WB_valid};
    checks++;
    if (regs !== '0) begin
      errors++; $display("FAIL reset_regs: got %h expected 0", regs);
    end
    checks++;
    if ({bus.EX_rf_wsel, bus.MEM_rf_wsel, bus.WB_rf_wsel} !== {3{S_ALU_C}}) begin
      errors++; $display("FAIL reset_wsel: got %h expected %h",
                         {bus.EX_rf_wsel, bus.MEM_rf_wsel, bus.WB_rf_wsel}, {3{S_ALU_C}});
    end
    checks++;
    if ({bus.stall_cnt, bus.flush_cnt, bus.retire_cnt} !== 96'd0) begin
      errors++; $display("FAIL reset_cnt: got %h expected 0",
                         {bus.stall_cnt, bus.flush_cnt, bus.retire_cnt});
    end
  endtask

  task automatic test_straight();
    do_reset();
    issue(5'd5, 1'b1, S_ALU_C, 32'h8, 32'h10);
    step();
    checks++;
    if ({bus.EX_wR, bus.EX_rf_we, bus.EX_pc4} !== {5'd5, 1'b1, 32'h8}) begin
      errors++; $display("FAIL straight_ex: got %h expected %h",
                         {bus.EX_wR, bus.EX_rf_we, bus.EX_pc4}, {5'd5, 1'b1, 32'h8});
    end
    idle();
    bus.EX_alu_c = 32'h1234;
    step();
    checks++;
    if ({bus.MEM_alu_c, bus.MEM_wR, bus.EX_rf_we} !== {32'h1234, 5'd5, 1'b0}) begin
      errors++; $display("FAIL straight_mem: got %h expected %h",
                         {bus.MEM_alu_c, bus.MEM_wR, bus.EX_rf_we}, {32'h1234, 5'd5, 1'b0});
    end
    idle();
    bus.MEM_rd_in = 32'hdead_beef;
    step();
    checks++;
    if ({bus.WB_alu_c, bus.WB_valid, bus.WB_rf_we, bus.WB_rd, bus.WB_ext} !==
        {32'h1234, 1'b1, 1'b1, 32'hdead_beef, 32'h10}) begin
      errors++; $display("FAIL straight_wb: got %h expected %h",
                         {bus.WB_alu_c, bus.WB_valid, bus.WB_rf_we, bus.WB_rd, bus.WB_ext},
                         {32'h1234, 1'b1, 1'b1, 32'hdead_beef, 32'h10});
    end
    idle();
    step();
    checks++;
    if ({bus.retire_cnt, bus.WB_valid} !== {32'd1, 1'b0}) begin
      errors++; $display("FAIL straight_retire: got %h expected %h",
                         {bus.retire_cnt, bus.WB_valid}, {32'd1, 1'b0});
    end
    // x0 destination is not filtered here
    issue(5'd0, 1'b1, S_SEXT_ext, 32'h4, 32'h4);
    step();
    checks++;
    if ({bus.EX_wR, bus.EX_rf_we, bus.EX_rf_wsel} !== {5'd0, 1'b1, S_SEXT_ext}) begin
      errors++; $display("FAIL x0_pass: got %h expected %h",
                         {bus.EX_wR, bus.EX_rf_we, bus.EX_rf_wsel}, {5'd0, 1'b1, S_SEXT_ext});
    end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(5'd7, 1'b1, S_DRAM_rd, 32'h20, 32'h0);
    step();
    issue(5'd8, 1'b1, S_ALU_C, 32'h24, 32'h0);
    bus.data_hazard = 1;
    #1;
    checks++;
    if ({bus.pc_stall, bus.ifid_stall, bus.ifid_flush} !== 3'b110) begin
      errors++; $display("FAIL lu_ctrl: got %b expected 110",
                         {bus.pc_stall, bus.ifid_stall, bus.ifid_flush});
    end
    step();
    bus.data_hazard = 0;
    bus.MEM_rd_in = 32'h0000_abcd;
    #1;
    checks++;
    if ({bus.EX_rf_we, bus.EX_wR, bus.MEM_wR, bus.MEM_rf_we, bus.MEM_rf_wsel, bus.MEM_rd} !==
        {1'b0, 5'd0, 5'd7, 1'b1, S_DRAM_rd, 32'h0000_abcd}) begin
      errors++; $display("FAIL lu_bubble: got %h expected %h",
                         {bus.EX_rf_we, bus.EX_wR, bus.MEM_wR, bus.MEM_rf_we, bus.MEM_rf_wsel,
                          bus.MEM_rd}, {1'b0, 5'd0, 5'd7, 1'b1, S_DRAM_rd, 32'h0000_abcd});
    end
    checks++;
    if (bus.stall_cnt !== 32'd1) begin
      errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", bus.stall_cnt);
    end
    step();
    checks++;
    if ({bus.EX_wR, bus.WB_wR, bus.WB_rd} !== {5'd8, 5'd7, 32'h0000_abcd}) begin
      errors++; $display("FAIL lu_resume: got %h expected %h",
                         {bus.EX_wR, bus.WB_wR, bus.WB_rd}, {5'd8, 5'd7, 32'h0000_abcd});
    end
  endtask

  task automatic test_redirect();
    do_reset();
    issue(5'd1, 1'b1, S_PC4, 32'h104, 32'h40);
    step();
    issue(5'd9, 1'b1, S_ALU_C, 32'h108, 32'h0);
    bus.EX_redirect = 1;
    #1;
    checks++;
    if ({bus.pc_stall, bus.ifid_stall, bus.ifid_flush} !== 3'b001) begin
      errors++; $display("FAIL rd_ctrl: got %b expected 001",
                         {bus.pc_stall, bus.ifid_stall, bus.ifid_flush});
    end
    step();
    idle();
    checks++;
    if ({bus.EX_rf_we, bus.EX_wR, bus.MEM_pc4, bus.MEM_rf_we, bus.MEM_wR, bus.MEM_rf_wsel} !==
        {1'b0, 5'd0, 32'h104, 1'b1, 5'd1, S_PC4}) begin
      errors++; $display("FAIL rd_advance: got %h expected %h",
                         {bus.EX_rf_we, bus.EX_wR, bus.MEM_pc4, bus.MEM_rf_we, bus.MEM_wR,
                          bus.MEM_rf_wsel}, {1'b0, 5'd0, 32'h104, 1'b1, 5'd1, S_PC4});
    end
    checks++;
    if (bus.flush_cnt !== 32'd1) begin
      errors++; $display("FAIL rd_flush_cnt: got %0d expected 1", bus.flush_cnt);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    issue(5'd3, 1'b1, S_ALU_C, 32'h10, 32'h0);
    bus.data_hazard = 1;
    bus.EX_redirect = 1;
    #1;
    checks++;
    if ({bus.pc_stall, bus.ifid_stall, bus.ifid_flush} !== 3'b001) begin
      errors++; $display("FAIL sim_ctrl: got %b expected 001",
                         {bus.pc_stall, bus.ifid_stall, bus.ifid_flush});
    end
    step();
    idle();
    checks++;
    if ({bus.stall_cnt, bus.flush_cnt, bus.EX_rf_we} !== {32'd0, 32'd1, 1'b0}) begin
      errors++; $display("FAIL sim_cnt: got %h expected %h",
                         {bus.stall_cnt, bus.flush_cnt, bus.EX_rf_we}, {32'd0, 32'd1, 1'b0});
    end
  endtask

  task automatic test_saturation();
    logic [3:0] exp4;
    do_reset();
    issue(5'd4, 1'b1, S_ALU_C, 32'h0, 32'h0);
    bus.data_hazard = 1;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp4 = (k > 15) ? 4'd15 : 4'(k);
      checks++;
      if (bus_s.stall_cnt !== exp4) begin
        errors++; $display("FAIL sat_cnt k=%0d: got %0d expected %0d", k, bus_s.stall_cnt, exp4);
      end
    end
    checks++;
    if ({bus.stall_cnt, bus.EX_rf_we, bus.WB_valid} !== {32'd20, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sat_wide: got %h expected %h",
                         {bus.stall_cnt, bus.EX_rf_we, bus.WB_valid}, {32'd20, 1'b0, 1'b0});
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      issue(5'(k + 10), 1'b1, S_SEXT_ext, 32'(k), 32'(k + 1));
      step();
    end
    bus.data_hazard = 1;
    step();
    #3;
    rst_n = 0;
    #1;
    checks++;
    if ({bus.EX_rf_we, bus.EX_wR, bus.MEM_rf_we, bus.MEM_wR, bus.WB_valid, bus.WB_wR,
         bus.MEM_ext, bus.WB_ext} !== '0) begin
      errors++; $display("FAIL midrst_regs: got %h expected 0",
                         {bus.EX_rf_we, bus.EX_wR, bus.MEM_rf_we, bus.MEM_wR, bus.WB_valid,
                          bus.WB_wR, bus.MEM_ext, bus.WB_ext});
    end
    checks++;
    if ({bus.stall_cnt, bus.retire_cnt, bus_s.stall_cnt, bus.EX_rf_wsel} !=
        {32'd0, 32'd0, 4'd0, S_ALU_C}) begin
      errors++; $display("FAIL midrst_cnt: got %h expected 0",
                         {bus.stall_cnt, bus.retire_cnt, bus_s.stall_cnt, bus.EX_rf_wsel});
    end
    idle();
    step();
    rst_n = 1;
  endtask

  // Random stream with hazards and redirects; expected WB descriptors queued at issue.
  task automatic test_stream();
    localparam int N = 40;
    wb_desc_t    tbl [N+4];
    logic [31:0] alu [N+4];
    logic [31:0] rdv [N+4];
    logic        hz  [N+4];
    logic        rdr [N+4];
    wb_desc_t    q [$];
    wb_desc_t    e;
    int          n_stall = 0, n_flush = 0, n_ret = 0;
    do_reset();
    for (int i = 0; i < N + 4; i++) begin
      tbl[i] = BubbleDesc;
      if (i < N) begin
        tbl[i].valid = ($urandom_range(0, 4) != 0);
        tbl[i].wr = 5'($urandom_range(0, 31));
        tbl[i].rf_we = 1'($urandom_range(0, 1));
        tbl[i].rf_wsel = 2'($urandom_range(0, 3));
        tbl[i].pc4 = $urandom;
        tbl[i].ext = $urandom;
      end
      alu[i] = $urandom;
      rdv[i] = $urandom;
      hz[i]  = (i < N) && ($urandom_range(0, 3) == 0);
      rdr[i] = (i < N) && ($urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < N + 4; i++) begin
      bus.ID_valid = tbl[i].valid; bus.ID_wR = tbl[i].wr; bus.ID_rf_we = tbl[i].rf_we;
      bus.ID_rf_wsel = tbl[i].rf_wsel; bus.ID_pc4 = tbl[i].pc4; bus.ID_ext = tbl[i].ext;
      bus.EX_alu_c = alu[i]; bus.MEM_rd_in = rdv[i];
      bus.data_hazard = hz[i]; bus.EX_redirect = rdr[i];
      if (hz[i] && !rdr[i]) n_stall++;
      if (rdr[i]) n_flush++;
      if (tbl[i].valid && !hz[i] && !rdr[i]) begin
        e = tbl[i];
        e.alu_c = alu[i+1];
        e.rd = rdv[i+2];
        q.push_back(e);
      end
      step();
      if (bus.WB_valid === 1'b1) begin
        n_ret++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_extra: got retire at step %0d expected none", i);
        end else begin
          e = q.pop_front();
          if ({bus.WB_wR, bus.WB_rf_we, bus.WB_rf_wsel, bus.WB_pc4, bus.WB_ext, bus.WB_alu_c,
               bus.WB_rd} !== {e.wr, e.rf_we, e.rf_wsel, e.pc4, e.ext, e.alu_c, e.rd}) begin
            errors++; $display("FAIL stream_wb step %0d: got %h expected %h", i,
                               {bus.WB_wR, bus.WB_rf_we, bus.WB_rf_wsel, bus.WB_pc4, bus.WB_ext,
                                bus.WB_alu_c, bus.WB_rd},
                               {e.wr, e.rf_we, e.rf_wsel, e.pc4, e.ext, e.alu_c, e.rd});
          end
        end
      end
    end
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL stream_missing: got %0d left expected 0", q.size());
    end
    checks++;
    if ({bus.stall_cnt, bus.flush_cnt, bus.retire_cnt} !==
        {32'(n_stall), 32'(n_flush), 32'(n_ret)}) begin
      errors++; $display("FAIL stream_cnts: got %0d/%0d/%0d expected %0d/%0d/%0d",
                         bus.stall_cnt, bus.flush_cnt, bus.retire_cnt, n_stall, n_flush, n_ret);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_straight();
    test_load_use();
    test_redirect();
    test_simultaneous();
    test_saturation();
    test_reset_mid();
    test_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
